// File: rtl/vga_sync_monitor_if.sv
// vga_sync_monitor_if: sync/pixel stream seen by the VGA sync monitor plus
// the monitor's recovered coordinates, lock status, error counters and probe.
// master: the side that produces sync/rgb and reads results (generator/bench).
// slave:  the monitor itself.
interface vga_sync_monitor_if;
    logic        hSync;
    logic        vSync;
    logic [11:0] rgb;
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        locked;
    logic        line_err;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [15:0] frame_count;
    logic [11:0] probe_rgb;
    logic        probe_valid;

    modport master (
        output hSync, vSync, rgb, probe_x, probe_y,
        input  hCount, vCount, locked, line_err, frame_err,
               err_count, frame_count, probe_rgb, probe_valid
    );

    modport slave (
        input  hSync, vSync, rgb, probe_x, probe_y,
        output hCount, vCount, locked, line_err, frame_err,
               err_count, frame_count, probe_rgb, probe_valid
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for VGA sync timing. Recovers pixel
// and line coordinates from hSync/vSync, checks line and frame timing,
// declares lock after LOCK_FRAMES consecutive good frames and counts errors.
// Optional pixel probe compiled in when VGA_SYNC_MON_PROBE_EN is defined.
module vga_sync_monitor #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_PULSE     = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_PULSE     = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              ClkPort,
    input  logic              Reset,
    vga_sync_monitor_if.slave bus
);
    localparam int LINE_CYC = H_TOTAL * CLK_DIV;
    localparam int PW_CYC   = H_PULSE * CLK_DIV;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    logic r_hs_s1, r_hs_s2, r_hs_d;
    logic r_vs_s1, r_vs_s2, r_vs_d;
    logic w_h_fall, w_v_fall;

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_count, r_v_count;
    logic [11:0]      r_line_cyc, r_pw_cyc;
    logic [9:0]       r_v_pw;
    logic             r_h_seen, r_frame_bad;

    state_t      r_state;
    logic [7:0]  r_good;
    logic        r_locked, r_line_err, r_frame_err;
    logic [7:0]  r_err_count;
    logic [15:0] r_frame_count;

    logic       w_pix_end, w_line_bad, w_line_sat, w_line_err;
    logic       w_frame_ok, w_frame_eval, w_frame_err, w_frame_good;
    logic [8:0] w_err_sum;
    logic [7:0] w_err_next;

    // Synchronize the sync inputs and keep one extra stage for edge detection.
    // Flops clear to 0 so a low pin at reset release never looks like a fall.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_hs_s1 <= 1'b0; r_hs_s2 <= 1'b0; r_hs_d <= 1'b0;
            r_vs_s1 <= 1'b0; r_vs_s2 <= 1'b0; r_vs_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the value
            // from before this edge, which is what builds a real shift chain.
            r_hs_s1 <= bus.hSync; r_hs_s2 <= r_hs_s1; r_hs_d <= r_hs_s2;
            r_vs_s1 <= bus.vSync; r_vs_s2 <= r_vs_s1; r_vs_d <= r_vs_s2;
        end
    end

    assign w_h_fall  = ~r_hs_s2 & r_hs_d;
    assign w_v_fall  = ~r_vs_s2 & r_vs_d;
    assign w_pix_end = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    // A line is judged at the hSync fall that closes it; the very first fall
    // after reset only opens a line. line_cyc hitting 4095 flags a lost hSync.
    assign w_line_bad = w_h_fall & r_h_seen &
                        ((({1'b0, r_line_cyc} + 13'd1) != 13'(LINE_CYC)) |
                         (r_pw_cyc != 12'(PW_CYC)));
    assign w_line_sat = ~w_h_fall & r_h_seen & (r_line_cyc == 12'hFFE);
    assign w_line_err = w_line_bad | w_line_sat;

    // Frame verdict at the vSync fall; a line closed in the same cycle still
    // belongs to the frame being judged.
    assign w_frame_ok   = (({1'b0, r_v_count} + 11'd1) == 11'(V_TOTAL)) &
                          (r_v_pw == 10'(V_PULSE)) & ~r_frame_bad & ~w_line_err;
    assign w_frame_eval = w_v_fall & (r_state != SEARCH);
    assign w_frame_err  = w_frame_eval & ~w_frame_ok;
    assign w_frame_good = w_frame_eval & w_frame_ok;

    assign w_err_sum  = {1'b0, r_err_count} + {8'd0, w_line_err} + {8'd0, w_frame_err};
    assign w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    // Pixel phase and recovered coordinates; vSync fall wins over hSync fall.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_div_cnt <= '0;
            r_h_count <= '0;
            r_v_count <= '0;
        end else begin
            if (w_h_fall) begin
                r_div_cnt <= '0;
                r_h_count <= '0;
            end else begin
                r_div_cnt <= w_pix_end ? '0 : r_div_cnt + DIV_W'(1);
                if (w_pix_end) r_h_count <= r_h_count + 10'd1;
            end
            if (w_v_fall)
                r_v_count <= '0;
            else if (w_h_fall && r_v_count != 10'h3FF)
                r_v_count <= r_v_count + 10'd1;
        end
    end

    // Line length, hSync pulse width, vSync pulse width and per-frame line errors.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_line_cyc  <= '0;
            r_pw_cyc    <= '0;
            r_h_seen    <= 1'b0;
            r_v_pw      <= '0;
            r_frame_bad <= 1'b0;
        end else begin
            if (w_h_fall) begin
                r_line_cyc <= '0;
                r_pw_cyc   <= 12'd1;
                r_h_seen   <= 1'b1;
            end else begin
                if (r_line_cyc != 12'hFFF) r_line_cyc <= r_line_cyc + 12'd1;
                if (!r_hs_s2 && r_pw_cyc != 12'hFFF) r_pw_cyc <= r_pw_cyc + 12'd1;
            end
            if (w_v_fall) begin
                r_v_pw      <= w_h_fall ? 10'd1 : 10'd0;
                r_frame_bad <= 1'b0;
            end else begin
                if (w_h_fall && !r_vs_s2 && r_v_pw != 10'h3FF) r_v_pw <= r_v_pw + 10'd1;
                if (w_line_err) r_frame_bad <= 1'b1;
            end
        end
    end

    // Lock state machine with registered lock flag, error pulses and counters.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_state       <= SEARCH;
            r_good        <= '0;
            r_locked      <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_count   <= '0;
            r_frame_count <= '0;
        end else begin
            r_line_err  <= w_line_err;
            r_frame_err <= w_frame_err;
            r_err_count <= w_err_next;
            if (w_frame_good) r_frame_count <= r_frame_count + 16'd1;
            case (r_state)
                SEARCH: begin
                    if (w_v_fall) begin
                        r_state <= MEASURE;
                        r_good  <= '0;
                    end
                end
                MEASURE: begin
                    if (w_frame_good) begin
                        r_good <= r_good + 8'd1;
                        if ((r_good + 8'd1) >= 8'(LOCK_FRAMES)) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_frame_err) begin
                        r_good <= '0;
                    end
                end
                LOCKED: begin
                    if (w_line_err || w_frame_err) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hCount      = r_h_count;
    assign bus.vCount      = r_v_count;
    assign bus.locked      = r_locked;
    assign bus.line_err    = r_line_err;
    assign bus.frame_err   = r_frame_err;
    assign bus.err_count   = r_err_count;
    assign bus.frame_count = r_frame_count;

`ifdef VGA_SYNC_MON_PROBE_EN
    logic [11:0] r_rgb_s1, r_rgb_s2, r_rgb_d, r_probe_rgb;
    logic        r_probe_valid;

    // rgb goes through the same three stages as the syncs, so r_rgb_d is the
    // pixel currently indexed by hCount; capture it on the last cycle of that pixel.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_rgb_s1      <= '0;
            r_rgb_s2      <= '0;
            r_rgb_d       <= '0;
            r_probe_rgb   <= '0;
            r_probe_valid <= 1'b0;
        end else begin
            r_rgb_s1      <= bus.rgb;
            r_rgb_s2      <= r_rgb_s1;
            r_rgb_d       <= r_rgb_s2;
            r_probe_valid <= 1'b0;
            if (r_locked && w_pix_end && !w_h_fall &&
                r_h_count == bus.probe_x && r_v_count == bus.probe_y) begin
                r_probe_rgb   <= r_rgb_d;
                r_probe_valid <= 1'b1;
            end
        end
    end

    assign bus.probe_rgb   = r_probe_rgb;
    assign bus.probe_valid = r_probe_valid;
`else
    logic w_probe_unused;
    assign w_probe_unused  = ^{bus.rgb, bus.probe_x, bus.probe_y};
    assign bus.probe_rgb   = '0;
    assign bus.probe_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: drives a scaled-down VGA stream (8 px x 6 lines,
// 2 clocks per pixel) into vga_sync_monitor. Expected error/lock events are
// queued as stimulus is issued; a monitor process pops them when the DUT
// pulses line_err/frame_err or raises locked.
module tb_vga_sync_monitor;
    localparam int CLK_DIV     = 2;
    localparam int H_TOTAL     = 8;
    localparam int H_PULSE     = 2;
    localparam int V_TOTAL     = 6;
    localparam int V_PULSE     = 2;
    localparam int LOCK_FRAMES = 2;
    localparam int PX          = 3;
    localparam int PY          = 4;

    typedef enum logic [1:0] {EV_LINE, EV_FRAME, EV_LOCK} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  ec;
        logic [15:0] fc;
    } ev_t;

    ev_t sb_q[$];

    logic ClkPort = 1'b0;
    logic Reset   = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   probe_pulses = 0;

    vga_sync_monitor_if bus ();

    vga_sync_monitor #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_PULSE(H_PULSE),
        .V_TOTAL(V_TOTAL), .V_PULSE(V_PULSE), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .ClkPort(ClkPort),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t kind, input int ec, input int fc);
        ev_t e;
        e.kind = kind;
        e.ec   = 8'(ec);
        e.fc   = 16'(fc);
        sb_q.push_back(e);
    endtask

    // Pixels p_from..p_to-1 of one line; hSync low for the first H_PULSE pixels.
    task automatic send_seg(input int p_from, input int p_to, input bit vs_low, input int line);
        for (int p = p_from; p < p_to; p++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge ClkPort);
                bus.hSync = (p < H_PULSE) ? 1'b0 : 1'b1;
                bus.vSync = vs_low ? 1'b0 : 1'b1;
                bus.rgb   = (line == PY && p == PX) ? 12'hF00 : 12'h0AA;
            end
        end
    endtask

    task automatic send_frame(input int long_line);
        for (int l = 0; l < V_TOTAL; l++)
            send_seg(0, (l == long_line) ? H_TOTAL + 1 : H_TOTAL, l < V_PULSE, l);
    endtask

    // Scoreboard monitor: every error pulse or lock rise must match the queue head.
    initial begin : monitor
        logic prev_locked;
        ev_t  e;
        prev_locked = 1'b0;
        forever begin
            @(negedge ClkPort);
            if (Reset) begin
                prev_locked = 1'b0;
            end else begin
                if (bus.probe_valid) probe_pulses++;
                if (bus.line_err || bus.frame_err || (bus.locked && !prev_locked)) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: got line_err=%0b frame_err=%0b locked=%0b err_count=%0d with no event expected",
                                 bus.line_err, bus.frame_err, bus.locked, bus.err_count);
                    end else begin
                        e = sb_q.pop_front();
                        case (e.kind)
                            EV_LINE:  check("sb_line_evt", {bus.line_err, bus.frame_err, bus.locked}, 3'b100);
                            EV_FRAME: check("sb_frame_evt", {bus.line_err, bus.frame_err, bus.locked}, 3'b010);
                            default: begin
                                check("sb_lock_evt", {bus.line_err, bus.frame_err, bus.locked}, 3'b001);
                                check("sb_lock_frame_count", bus.frame_count, e.fc);
                            end
                        endcase
                        check("sb_err_count", bus.err_count, e.ec);
                    end
                end
                prev_locked = bus.locked;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.hSync = 1'b1;
        bus.vSync = 1'b1;
        bus.rgb   = 12'h0AA;
        bus.probe_x = 10'(PX);
        bus.probe_y = 10'(PY);
        repeat (3) @(negedge ClkPort);

        // Reset values
        check("rst_hCount", bus.hCount, 0);
        check("rst_vCount", bus.vCount, 0);
        check("rst_flags", {bus.locked, bus.line_err, bus.frame_err, bus.probe_valid}, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_probe_rgb", bus.probe_rgb, 0);
        Reset = 1'b0;
        repeat (5) @(negedge ClkPort);

        // Nominal: SEARCH->MEASURE at F0 start, lock at F2 start with 2 good frames
        push_ev(EV_LOCK, 0, 2);
        send_frame(-1);
        send_frame(-1);
        send_frame(-1);
        probe_pulses = 0;
        send_frame(-1);
        check("nom_locked", bus.locked, 1);
        check("nom_frame_count", bus.frame_count, 3);
        check("nom_err_count", bus.err_count, 0);
        // Generator at last cycle of pixel 7, line 5; monitor lags 3 clocks -> pixel 6
        check("nom_hCount", bus.hCount, H_TOTAL - 2);
        check("nom_vCount", bus.vCount, V_TOTAL - 1);
`ifdef VGA_SYNC_MON_PROBE_EN
        check("probe_pulses", probe_pulses, 1);
        check("probe_rgb", bus.probe_rgb, 12'hF00);
`else
        check("probe_pulses", probe_pulses, 0);
        check("probe_rgb", bus.probe_rgb, 0);
`endif

        // Long line (9 px) in F4 while locked -> one line_err, drop lock
        push_ev(EV_LINE, 1, 0);
        send_frame(3);
        check("long_locked", bus.locked, 0);
        check("long_err_count", bus.err_count, 1);
        // Relock: F5 start -> MEASURE, F5/F6 good, lock at F7 start (F0-F3,F5,F6 counted)
        push_ev(EV_LOCK, 1, 6);
        send_frame(-1);
        send_frame(-1);
        send_frame(-1);
        check("relock_locked", bus.locked, 1);
        check("relock_frame_count", bus.frame_count, 6);

        // Missing vSync: 1030 lines with vSync high, vCount saturates
        for (int i = 0; i < 1030; i++) send_seg(0, H_TOTAL, 1'b0, -1);
        check("nov_vCount_sat", bus.vCount, 10'h3FF);
        check("nov_locked", bus.locked, 1);
        push_ev(EV_FRAME, 2, 0);
        send_frame(-1);
        check("nov_unlocked", bus.locked, 0);
        check("nov_frame_count", bus.frame_count, 6);

        // Error saturation: 300 short lines, each judged at the next hSync fall
        for (int k = 0; k < 300; k++) begin
            if (k > 0) push_ev(EV_LINE, (2 + k > 255) ? 255 : 2 + k, 0);
            send_seg(0, 3, 1'b0, -1);
        end
        push_ev(EV_LINE, 255, 0);
        send_seg(0, H_TOTAL, 1'b0, -1);
        check("sat_err_count", bus.err_count, 255);

        // Relock, then reset mid-line while locked
        push_ev(EV_LOCK, 255, 8);
        send_frame(-1);
        send_frame(-1);
        for (int l = 0; l < 3; l++) send_seg(0, H_TOTAL, l < V_PULSE, l);
        send_seg(0, 4, 1'b0, 3);
        check("pre_rst_locked", bus.locked, 1);
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_counts", {bus.hCount, bus.vCount}, 0);
        check("mid_rst_flags", {bus.locked, bus.line_err, bus.frame_err}, 0);
        check("mid_rst_err_count", bus.err_count, 0);
        check("mid_rst_frame_count", bus.frame_count, 0);
        @(negedge ClkPort);
        Reset = 1'b0;
        send_seg(4, H_TOTAL, 1'b0, 3);
        for (int l = 4; l < V_TOTAL; l++) send_seg(0, H_TOTAL, 1'b0, l);
        check("post_rst_locked", bus.locked, 0);
        // F13 start -> MEASURE, F13/F14 good, lock at F15 start
        push_ev(EV_LOCK, 0, 2);
        send_frame(-1);
        send_frame(-1);
        send_frame(-1);
        check("final_locked", bus.locked, 1);
        check("final_frame_count", bus.frame_count, 2);
        check("final_err_count", bus.err_count, 0);

        repeat (10) @(negedge ClkPort);
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

- Receive-side counterpart of the VGA timing generator: samples `hSync`/`vSync` (and optionally `rgb`) as they leave the top level.
- Recovers pixel and line coordinates, checks 640x480@60 timing, declares lock, counts timing errors.
- Sits beside the VGA output path as an on-chip self-check, and serves as the scoreboard front end in the top-level bench.

## Interface
Parameters:
- `CLK_DIV`, 4: ClkPort cycles per pixel.
- `H_TOTAL`, 800: pixels per line.
- `H_PULSE`, 96: hSync low width, pixels.
- `V_TOTAL`, 525: lines per frame.
- `V_PULSE`, 2: vSync low width, lines.
- `LOCK_FRAMES`, 2: consecutive good frames required for lock.

Ports:
- `ClkPort` in 1: 100 MHz system clock.
- `Reset` in 1: asynchronous, active-high.
- `hSync` in 1: horizontal sync, active-low.
- `vSync` in 1: vertical sync, active-low.
- `rgb` in 12: pixel colour {R,G,B}; used only with probe.
- `probe_x` in 10: probe column, hCount space.
- `probe_y` in 10: probe row, vCount space.
- `hCount` out 10: recovered pixel index.
- `vCount` out 10: recovered line index.
- `locked` out 1: timing locked.
- `line_err` out 1: one-cycle pulse on a bad line.
- `frame_err` out 1: one-cycle pulse on a bad frame.
- `err_count` out 8: saturating error count.
- `frame_count` out 16: good frames seen; wraps.
- `probe_rgb` out 12: captured pixel.
- `probe_valid` out 1: one-cycle pulse when `probe_rgb` updates.

## Operation
- Input conditioning:
  - `hSync` and `vSync` each pass a 2-flop synchronizer, then an edge register.
  - A falling edge is recognised when the synchronized value is 0 and the registered value is 1.
- Pixel phase:
  - `div_cnt` runs 0..CLK_DIV-1 and is forced to 0 on each hSync falling edge.
  - hCount increments when `div_cnt == CLK_DIV-1`.
  - hSync fall sets hCount=0.
- Line accounting:
  - `line_cyc` (12 bits) counts ClkPort cycles since the last hSync fall.
  - `pw_cyc` counts cycles hSync is low.
  - At each hSync fall: line good iff `line_cyc+1 == H_TOTAL*CLK_DIV` and `pw_cyc == H_PULSE*CLK_DIV`.
  - If `line_cyc` reaches 4095 without an hSync fall, it saturates and raises line_err once.
- Frame accounting:
  - vCount increments on each hSync fall; saturates at 1023.
  - vSync fall sets vCount=0.
  - Frame good iff lines counted == V_TOTAL, vSync low lasted exactly V_PULSE hSync falls, and no line_err occurred in the frame.
- States:
  - SEARCH: wait for vSync fall, then go to MEASURE with good=0.
  - MEASURE: on vSync fall, a good frame gives good+1 and the state goes to LOCKED when good reaches LOCK_FRAMES. A bad frame gives frame_err and good=0.
  - LOCKED: on any line_err or frame_err, go to SEARCH with locked=0.
  - `locked` = (state == LOCKED).
- Error counters:
  - err_count += 1 per line_err or frame_err pulse, saturating at 255.
  - line_err and frame_err in the same cycle add 2, saturating.
- frame_count: +1 per good frame in any state; wraps at 65535 to 0.
- Reset values: every output and counter 0, state SEARCH.

## Timing
- Latency:
  - Edge detection fires 3 ClkPort cycles after a pin transition: 2 sync stages plus the edge register.
  - All outputs are registered.
  - hCount/vCount lag the generator's counters by 3 ClkPort cycles (sub-pixel) and are otherwise equal when locked.
- Error pulses: line_err and frame_err assert for exactly 1 cycle, in the cycle after the offending edge is recognised.
- Simultaneous edges: when hSync and vSync fall in the same cycle, apply the line check first, then the frame check; vCount ends at 0.
- Reset asserted mid-frame: immediate return to reset values, with no error pulse on release.
- First partial frame: the first partial frame after reset or SEARCH is never counted as good or bad.

## Configuration
- `VGA_SYNC_MON_PROBE_EN` defined: pixel probe compiled in.
  - The 12-bit `rgb` input is synchronized through 2 flops and aligned with the sync path.
  - When locked and (hCount,vCount)==(probe_x,probe_y) on a pixel boundary (`div_cnt == CLK_DIV-1`), `probe_rgb` captures it and `probe_valid` pulses once per frame.
- Undefined: no rgb flops; `probe_rgb`=0 and `probe_valid`=0 constantly.

## Test plan
- Nominal stream: ideal 800x525 stream, CLK_DIV=4 → locked=1 at the 3rd vSync fall (SEARCH→MEASURE, then 2 good frames), err_count=0, frame_count=2 at lock.
- Long line: one line of 801 pixels while locked → line_err one pulse, locked=0 within 1 cycle, err_count=1, relock after 2 further good frames.
- Missing vSync: vSync held high for 2 frames while locked → vCount saturates at 1023, frame_err at the next vSync fall, err_count increments.
- Error saturation: 300 forced bad lines → err_count=255, no wrap.
- Probe capture (macro defined): probe=(320,240), rgb=12'hF00 at that pixel → probe_rgb=12'hF00, probe_valid pulses once per frame. Macro undefined: probe_rgb=0.
- Reset during LOCKED mid-line → all outputs 0 within 1 cycle of Reset, SEARCH after release, no error pulse.
